// File: rtl/mshr_refill_unit_if.sv
// Bundle of cache-side and memory-side signals for the single-entry MSHR refill stage.
interface mshr_refill_unit_if #(
    parameter int ADR_WIDTH   = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int WORD_OFFSET = 2
);
    logic                   miss_req_i;
    logic [ADR_WIDTH-1:0]   miss_adr_i;
    logic                   miss_dirty_i;
    logic [ADR_WIDTH-1:0]   victim_adr_i;
    logic                   victim_vld_i;
    logic [WORD_OFFSET-1:0] mshr_victim_word_i;
    logic [DATA_WIDTH-1:0]  mshr_victim_dat_i;
    logic                   miss_ack_o;
    logic                   busy_o;
    logic                   load_vld_o;
    logic [WORD_OFFSET-1:0] mshr_load_word_o;
    logic [DATA_WIDTH-1:0]  mshr_load_dat_o;
    logic                   refill_done_o;
    logic                   mem_req_o;
    logic                   mem_we_o;
    logic [ADR_WIDTH-1:0]   mem_adr_o;
    logic [DATA_WIDTH-1:0]  mem_dat_o;
    logic                   mem_ack_i;
    logic [DATA_WIDTH-1:0]  mem_dat_i;

    modport slave (
        input  miss_req_i, miss_adr_i, miss_dirty_i, victim_adr_i,
               victim_vld_i, mshr_victim_word_i, mshr_victim_dat_i,
               mem_ack_i, mem_dat_i,
        output miss_ack_o, busy_o, load_vld_o, mshr_load_word_o, mshr_load_dat_o,
               refill_done_o, mem_req_o, mem_we_o, mem_adr_o, mem_dat_o
    );

    modport master (
        output miss_req_i, miss_adr_i, miss_dirty_i, victim_adr_i,
               victim_vld_i, mshr_victim_word_i, mshr_victim_dat_i,
               mem_ack_i, mem_dat_i,
        input  miss_ack_o, busy_o, load_vld_o, mshr_load_word_o, mshr_load_dat_o,
               refill_done_o, mem_req_o, mem_we_o, mem_adr_o, mem_dat_o
    );
endinterface

// File: rtl/mshr_refill_unit.sv
// Single-entry miss handler: captures a dirty victim, writes it back, then refills
// the missing line critical-word-first.
module mshr_refill_unit #(
    parameter int ADR_WIDTH   = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int WORD_OFFSET = 2
) (
    input  logic             clk,
    input  logic             rst,
    mshr_refill_unit_if.slave bus
);
    localparam int LINE_W = ADR_WIDTH - WORD_OFFSET - 2;
    localparam int WORDS  = 1 << WORD_OFFSET;

    typedef enum logic [1:0] {IDLE, VCAP, WB, FILL} state_t;

    state_t                 state_q, state_d;
    logic                   ack_q, ack_d;
    logic                   load_vld_q, load_vld_d;
    logic                   done_q, done_d;
    logic [WORD_OFFSET-1:0] load_word_q, load_word_d;
    logic [DATA_WIDTH-1:0]  load_dat_q, load_dat_d;
    logic                   mem_req_q, mem_req_d;
    logic                   mem_we_q, mem_we_d;
    logic [ADR_WIDTH-1:0]   mem_adr_q, mem_adr_d;
    logic [DATA_WIDTH-1:0]  mem_dat_q, mem_dat_d;
    logic [WORD_OFFSET-1:0] cnt_q, cnt_d;
    logic [WORD_OFFSET-1:0] crit_q, crit_d;
    logic [LINE_W-1:0]      miss_line_q, miss_line_d;
    logic [LINE_W-1:0]      victim_line_q, victim_line_d;
    logic [DATA_WIDTH-1:0]  vbuf_q [WORDS];
    logic [DATA_WIDTH-1:0]  vbuf_d [WORDS];
    logic [WORD_OFFSET-1:0] cnt_inc, fill_cur, fill_nxt;
    logic                   unused_adr_bits;

    assign unused_adr_bits = ^{bus.miss_adr_i[1:0], bus.victim_adr_i[WORD_OFFSET+1:0]};

    always_comb begin
        state_d       = state_q;
        ack_d         = 1'b0;
        load_vld_d    = 1'b0;
        done_d        = 1'b0;
        load_word_d   = load_word_q;
        load_dat_d    = load_dat_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_adr_d     = mem_adr_q;
        mem_dat_d     = mem_dat_q;
        cnt_d         = cnt_q;
        crit_d        = crit_q;
        miss_line_d   = miss_line_q;
        victim_line_d = victim_line_q;
        vbuf_d        = vbuf_q;
        cnt_inc       = cnt_q + 1'b1;
        fill_cur      = crit_q + cnt_q;
        fill_nxt      = crit_q + cnt_inc;

        case (state_q)
            IDLE: begin
                if (bus.miss_req_i) begin
                    ack_d         = 1'b1;
                    cnt_d         = '0;
                    miss_line_d   = bus.miss_adr_i[ADR_WIDTH-1 -: LINE_W];
                    crit_d        = bus.miss_adr_i[WORD_OFFSET+1:2];
                    victim_line_d = bus.victim_adr_i[ADR_WIDTH-1 -: LINE_W];
                    if (bus.miss_dirty_i) begin
                        state_d = VCAP;
                    end else begin
                        // Clean miss: first read beat goes out alongside the ack.
                        state_d   = FILL;
                        mem_req_d = 1'b1;
                        mem_we_d  = 1'b0;
                        mem_adr_d = {bus.miss_adr_i[ADR_WIDTH-1 -: LINE_W],
                                     bus.miss_adr_i[WORD_OFFSET+1:2], 2'b00};
                    end
                end
            end
            VCAP: begin
                if (bus.victim_vld_i) begin
                    vbuf_d[bus.mshr_victim_word_i] = bus.mshr_victim_dat_i;
                    cnt_d = cnt_inc;
                    if (cnt_q == '1) begin
                        // Read word 0 from the updated buffer so a final beat to word 0 is seen.
                        state_d   = WB;
                        mem_req_d = 1'b1;
                        mem_we_d  = 1'b1;
                        mem_adr_d = {victim_line_q, {WORD_OFFSET{1'b0}}, 2'b00};
                        mem_dat_d = vbuf_d[0];
                    end
                end
            end
            WB: begin
                if (bus.mem_ack_i) begin
                    cnt_d = cnt_inc;
                    if (cnt_q == '1) begin
                        state_d   = FILL;
                        mem_we_d  = 1'b0;
                        mem_adr_d = {miss_line_q, crit_q, 2'b00};
                    end else begin
                        mem_adr_d = {victim_line_q, cnt_inc, 2'b00};
                        mem_dat_d = vbuf_q[cnt_inc];
                    end
                end
            end
            FILL: begin
                if (bus.mem_ack_i) begin
                    load_vld_d  = 1'b1;
                    load_word_d = fill_cur;
                    load_dat_d  = bus.mem_dat_i;
                    cnt_d       = cnt_inc;
                    if (cnt_q == '1) begin
                        state_d   = IDLE;
                        mem_req_d = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        mem_adr_d = {miss_line_q, fill_nxt, 2'b00};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            ack_q         <= 1'b0;
            load_vld_q    <= 1'b0;
            done_q        <= 1'b0;
            load_word_q   <= '0;
            load_dat_q    <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_adr_q     <= '0;
            mem_dat_q     <= '0;
            cnt_q         <= '0;
            crit_q        <= '0;
            miss_line_q   <= '0;
            victim_line_q <= '0;
        end else begin
            state_q       <= state_d;
            ack_q         <= ack_d;
            load_vld_q    <= load_vld_d;
            done_q        <= done_d;
            load_word_q   <= load_word_d;
            load_dat_q    <= load_dat_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_adr_q     <= mem_adr_d;
            mem_dat_q     <= mem_dat_d;
            cnt_q         <= cnt_d;
            crit_q        <= crit_d;
            miss_line_q   <= miss_line_d;
            victim_line_q <= victim_line_d;
        end
    end

    always_ff @(posedge clk) begin
        vbuf_q <= vbuf_d;
    end

    assign bus.miss_ack_o       = ack_q;
    assign bus.busy_o           = (state_q != IDLE);
    assign bus.load_vld_o       = load_vld_q;
    assign bus.mshr_load_word_o = load_word_q;
    assign bus.mshr_load_dat_o  = load_dat_q;
    assign bus.refill_done_o    = done_q;
    assign bus.mem_req_o        = mem_req_q;
    assign bus.mem_we_o         = mem_we_q;
    assign bus.mem_adr_o        = mem_adr_q;
    assign bus.mem_dat_o        = mem_dat_q;
endmodule
